music_box_sequencer: RTL and testbench

MUSIC_BOX_SEQUENCER -- requirements
Module: music_box_sequencer

---
 rtl/music_box_pkg.sv | 22 ++
 rtl/music_box_sequencer_if.sv | 10 +
 rtl/music_box_sequencer_tick_gen.sv | 24 ++
 rtl/music_box_sequencer.sv | 112 +++++++++++
 tb/tb_music_box_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/music_box_pkg.sv
// Shared constants, state encoding and ROM word layout for the music box sequencer.
package music_box_pkg;

    localparam int          NUM_NOTES = 42;
    localparam logic [5:0]  REST_CODE = 6'd63;
    localparam logic [5:0]  END_CODE  = 6'd62;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, DECODE, PLAY, GAP, DONE
    } state_t;

    typedef struct packed {
        logic [5:0] code;
        logic [9:0] dur;
    } rom_word_t;

    // Codes 42..63 (including REST_CODE) map to silence.
    function automatic logic [NUM_NOTES-1:0] note_mask(input logic [5:0] code);
        note_mask = (code < 6'(NUM_NOTES)) ? (NUM_NOTES'(1) << code) : '0;
    endfunction

endpackage

// File: rtl/music_box_sequencer_if.sv
// Song ROM read port: the sequencer drives the address, the ROM answers one cycle later.
interface music_box_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/music_box_sequencer_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_CYCLES cycles, cleared while restart is high.
module tick_gen #(
    parameter int TICK_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = !restart && (cnt == CNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/music_box_sequencer.sv
// Music box sequencer: walks a song ROM of {code, duration} words and drives one-hot note enables.
module music_box_sequencer
    import music_box_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TICK_CYCLES = 500000,
    parameter int GAP_TICKS   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    music_box_sequencer_if.master rom,
    output logic [NUM_NOTES-1:0]  note_en,
    output logic                  busy,
    output logic                  done
);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    rom_word_t         word;
    logic [9:0]        dur_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              tick;
    logic              restart;

    // Prescaler is held at zero outside PLAY/GAP so each phase starts on a fresh tick;
    // the PLAY->GAP hand-off lands on the natural wrap of the counter.
    assign restart      = (state != PLAY) && (state != GAP);
    assign rom.rom_addr = addr;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr    <= '0;
            word    <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
            note_en <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                note_en <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= FETCH;
                        addr  <= '0;
                        busy  <= 1'b1;
                    end
                    FETCH: state <= WAIT;
                    WAIT: begin
                        state <= DECODE;
                        word  <= rom.rom_data;
                    end
                    DECODE: if (word.code == END_CODE) begin
                        state <= DONE;
                    end else begin
                        state   <= PLAY;
                        note_en <= note_mask(word.code);
                        dur_cnt <= (word.dur == 10'd0) ? 10'd1 : word.dur;
                    end
                    PLAY: if (tick) begin
                        if (dur_cnt <= 10'd1) begin
                            note_en <= '0;
                            if (GAP_TICKS == 0) begin
                                addr  <= addr + 1'b1;
                                state <= (addr == '1) ? DONE : FETCH;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= GAP_W'(GAP_TICKS);
                            end
                        end else begin
                            dur_cnt <= dur_cnt - 10'd1;
                        end
                    end
                    GAP: if (tick) begin
                        if (gap_cnt <= GAP_W'(1)) begin
                            // Running off the top of the ROM counts as end-of-song.
                            addr  <= addr + 1'b1;
                            state <= (addr == '1) ? DONE : FETCH;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    DONE: if (loop) begin
                        state <= FETCH;
                        addr  <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_music_box_sequencer.sv
// Directed vector bench for music_box_sequencer with TICK_CYCLES=4, GAP_TICKS=1.
`timescale 1ns/1ps
module tb_music_box_sequencer;
    localparam logic [41:0] N0  = 42'd0;
    localparam logic [41:0] N00 = 42'd1;
    localparam logic [41:0] N12 = 42'd1 << 12;
    localparam logic [41:0] N41 = 42'd1 << 41;

    typedef struct {
        int          rom_id;
        bit          start;
        bit          stop;
        bit          loop;
        int          reps;
        logic [41:0] note;
        bit          busy;
        bit          done;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        loop  = 1'b0;
    logic [41:0] note_en;
    logic        busy;
    logic        done;
    logic [15:0] rom [256];

    int n_vec = 0;
    int n_bad = 0;
    vec_t vtab[$];

    music_box_sequencer_if #(.ADDR_W(8)) rom_if ();

    music_box_sequencer #(.ADDR_W(8), .TICK_CYCLES(4), .GAP_TICKS(1)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .rom     (rom_if),
        .note_en (note_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clock) rom_if.rom_data <= rom[rom_if.rom_addr];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_rom(input int id);
        for (int i = 0; i < 256; i++) rom[i] = 16'hF800;
        case (id)
            0: rom[0] = 16'h3003;                       // code 12, dur 3
            1: begin rom[0] = 16'hFC02; rom[1] = 16'hC801; end
            2: rom[0] = 16'h0000;                       // code 0, dur 0
            3: rom[0] = 16'hA401;                       // code 41, dur 1
            4: for (int i = 0; i < 256; i++) rom[i] = 16'hFC01;
            default: ;
        endcase
    endtask

    task automatic add(input int id, input bit s, input bit p, input bit l, input int reps,
                       input logic [41:0] n, input bit b, input bit d);
        vtab.push_back('{id, s, p, l, reps, n, b, d});
    endtask

    initial begin
        // single note with start held while busy and retrigger after done
        add(0, 1,0,0, 1,  N0, 1,0);
        add(0, 0,0,0, 2,  N0, 1,0);
        add(0, 1,0,0, 12, N12,1,0);
        add(0, 0,0,0, 7,  N0, 1,0);
        add(0, 1,0,0, 1,  N0, 1,0);
        add(0, 1,0,0, 1,  N0, 0,1);
        add(0, 1,0,0, 1,  N0, 1,0);
        add(0, 0,1,0, 1,  N0, 0,0);
        add(0, 0,0,0, 1,  N0, 0,0);
        // stop beats start; stop mid-PLAY; replay from address 0
        add(0, 1,1,0, 2,  N0, 0,0);
        add(0, 1,0,0, 1,  N0, 1,0);
        add(0, 0,0,0, 2,  N0, 1,0);
        add(0, 0,0,0, 3,  N12,1,0);
        add(0, 0,1,0, 1,  N0, 0,0);
        add(0, 0,0,0, 3,  N0, 0,0);
        add(0, 1,0,0, 1,  N0, 1,0);
        add(0, 0,0,0, 2,  N0, 1,0);
        add(0, 0,0,0, 12, N12,1,0);
        add(0, 0,1,0, 1,  N0, 0,0);
        add(0, 0,0,0, 2,  N0, 0,0);
        // rests only: busy for 30 cycles, silent throughout
        add(1, 1,0,0, 1,  N0, 1,0);
        add(1, 0,0,0, 29, N0, 1,0);
        add(1, 0,0,0, 1,  N0, 0,1);
        add(1, 0,0,0, 1,  N0, 0,0);
        // dur 0 plays as one tick
        add(2, 1,0,0, 1,  N0, 1,0);
        add(2, 0,0,0, 2,  N0, 1,0);
        add(2, 0,0,0, 4,  N00,1,0);
        add(2, 0,0,0, 8,  N0, 1,0);
        add(2, 0,0,0, 1,  N0, 0,1);
        add(2, 0,0,0, 1,  N0, 0,0);
        // loop: second pass without done, loop dropped -> single done
        add(3, 1,0,1, 1,  N0, 1,0);
        add(3, 0,0,1, 2,  N0, 1,0);
        add(3, 0,0,1, 4,  N41,1,0);
        add(3, 0,0,1, 8,  N0, 1,0);
        add(3, 0,0,1, 3,  N0, 1,0);
        add(3, 0,0,1, 4,  N41,1,0);
        add(3, 0,0,0, 8,  N0, 1,0);
        add(3, 0,0,0, 1,  N0, 0,1);
        add(3, 0,0,0, 2,  N0, 0,0);
        // no END word: address wrap after 256 entries ends the song
        add(4, 1,0,0, 1,    N0, 1,0);
        add(4, 0,0,0, 2816, N0, 1,0);
        add(4, 0,0,0, 1,    N0, 0,1);
        add(4, 0,0,0, 1,    N0, 0,0);

        load_rom(0);
        #12;
        check("reset_note_en", 64'(note_en), 64'd0);
        check("reset_busy",    64'(busy),    64'd0);
        check("reset_done",    64'(done),    64'd0);
        check("reset_rom_addr",64'(rom_if.rom_addr), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        begin
            int cur_rom;
            cur_rom = 0;
            foreach (vtab[r]) begin
                if (vtab[r].rom_id != cur_rom) begin
                    cur_rom = vtab[r].rom_id;
                    load_rom(cur_rom);
                end
                for (int k = 0; k < vtab[r].reps; k++) begin
                    start = vtab[r].start;
                    stop  = vtab[r].stop;
                    loop  = vtab[r].loop;
                    @(posedge clock);
                    #1;
                    check($sformatf("row%0d.%0d note/busy/done", r, k),
                          64'({note_en, busy, done}),
                          64'({vtab[r].note, vtab[r].busy, vtab[r].done}));
                end
            end
        end
        start = 1'b0; stop = 1'b0; loop = 1'b0;

        // Asynchronous reset in the middle of a note
        load_rom(0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clock); #1;
                seen = (note_en != N0);
            end
            check("note_before_reset", 64'(note_en), 64'(N12));
        end
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("async_reset_note_en", 64'(note_en), 64'd0);
        check("async_reset_busy",    64'(busy),    64'd0);
        check("async_reset_addr",    64'(rom_if.rom_addr), 64'd0);
        #2;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_after_reset_busy", 64'(busy), 64'd1);
        repeat (3) @(posedge clock);
        #1;
        check("start_after_reset_note", 64'(note_en), 64'(N12));
        stop = 1'b1;
        @(posedge clock); #1;
        stop = 1'b0;
        check("final_stop", 64'({note_en, busy, done}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
